uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART serial receiver, 16x oversampled. Consumes the x16 baud output of the
//  UART baud generator and deserialises RxD (LSB first, 1 start, DATA_BITS
//  data, optional parity, 1 stop) into a parallel word. The word is held for
//  the core bus under a valid/ack handshake. Framing and overrun are flagged.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, legal range 5..8
//  PARITY_ODD  0  parity sense, used only with UART_RX_PARITY_EN: 0=even, 1=odd
// PORTS
//  Clock        in   1          system clock; all logic on posedge
//  Reset        in   1          synchronous, active-low reset
//  BaudClock16  in   1          x16 baud clock from baud generator, as a level
//  RxD          in   1          asynchronous serial input, idle high
//  RxAck        in   1          1-cycle pulse: consumer has taken RxData
//  RxData       out  DATA_BITS  received word, stable while RxValid=1
//  RxValid      out  1          holding register full
//  RxBusy       out  1          state != IDLE
//  RxFrameErr   out  1          1-cycle pulse: stop bit sampled 0
//  RxParErr     out  1          1-cycle pulse: parity mismatch
//  RxOverrun    out  1          1-cycle pulse: frame lost because holding was full
// BEHAVIOUR
//  - Reset (Reset=0 at posedge) sets: RxData=0, RxValid=0, RxBusy=0, all error
//    pulses=0, state=IDLE, counters=0, both sync FFs=1, tick-edge FF=0.
//    Reset mid-frame aborts the frame. No partial data is kept.
//  - RxD passes through a 2-FF synchroniser (rx_s). tick = rising edge of
//    BaudClock16, detected against a registered copy; it lasts one Clock.
//    All state advances only on tick. Handshake and reset act on every Clock.
//  - SampleCnt is 4 bits and BitCnt is 3 bits. States:
//    IDLE: on tick with rx_s=0 -> START, SampleCnt=0.
//    START: each tick, if SampleCnt==7 then check rx_s. rx_s=0 -> DATA with
//      SampleCnt=0, BitCnt=0. rx_s=1 -> IDLE (glitch, no flag). Otherwise
//      SampleCnt++.
//    DATA: each tick, if SampleCnt==15 then shift rx_s into the shift-register
//      MSB (shift right) and set SampleCnt=0. When BitCnt==DATA_BITS-1 go to
//      PARITY (if enabled) or STOP; otherwise BitCnt++. Otherwise SampleCnt++.
//    PARITY: sample at SampleCnt==15 the same way, then -> STOP.
//    STOP: sample at SampleCnt==15, then always -> IDLE.
//  - At the stop sample: rx_s=0 gives a RxFrameErr pulse and drops the word.
//    A parity mismatch gives a RxParErr pulse and drops the word.
//  - Otherwise the word is delivered on the next Clock: RxData=word, RxValid=1.
//  - A line held low (break) re-enters START after IDLE. Each 0 stop bit flags
//    RxFrameErr again.
//  - Latency: RxValid rises 152 ticks (DATA_BITS=8, no parity) after the tick
//    that detected the start edge, plus at most 1 Clock.
//  - Handshake: RxAck with RxValid=1 clears RxValid next Clock. RxAck with
//    RxValid=0 is ignored.
//  - Delivery while RxValid=1 and no RxAck in the same Clock: RxOverrun pulse,
//    RxData unchanged, new word dropped.
//  - Delivery and RxAck in the same Clock: new word loaded, RxValid stays 1,
//    no overrun.
//  - Error pulses and RxOverrun last exactly 1 Clock. They are not sticky.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    PARITY state present. Expected parity bit = ^data ^ PARITY_ODD.
//    A mismatch pulses RxParErr and drops the word.
//    Frame = 1 start + DATA_BITS + parity + 1 stop; latency +16 ticks.
//  UART_RX_PARITY_EN undefined:
//    No PARITY state or logic. PARITY_ODD is ignored. RxParErr is tied 0.
// TESTING
//  BaudClock16 toggles every Clock, so 1 tick = 2 Clocks and 1 bit = 32 Clocks.
//  1. Send 0xA5 in 8N1 -> RxValid=1, RxData=8'hA5, 152 ticks after start
//     detect. RxAck -> RxValid=0 next Clock.
//  2. RxD low for 4 ticks, then high -> START aborts at SampleCnt 7, RxBusy
//     returns to 0, no RxValid, no error pulse.
//  3. Send 0x3C with stop bit = 0 -> RxFrameErr pulse for 1 Clock, RxValid
//     stays 0.
//  4. Send 0x11 then 0x22 with no ack -> RxData=8'h11, RxOverrun pulse at the
//     second delivery. Then RxAck -> RxValid=0.
//  5. Assert Reset after the 3rd data bit of 0xFF -> all outputs are at reset
//     values next Clock. Then send 0x5A -> RxData=8'h5A, no error flags.
//  6. With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 0 ->
//     RxParErr pulse, RxValid=0. Same frame with parity bit 1 -> RxData=8'h07.

Source files
------------

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver with valid/ack holding register and error pulses.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 BaudClock16,
   input  logic                 RxD,
   input  logic                 RxAck,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   output logic                 RxBusy,
   output logic                 RxFrameErr,
   output logic                 RxParErr,
   output logic                 RxOverrun
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   function automatic logic exp_parity(input logic [DATA_BITS-1:0] word);
      return (^word) ^ PARITY_ODD;
   endfunction

   logic                 rx_meta_q, rx_s_q, baud_q, tick_s;
   logic [2:0]           state_q, state_d;
   logic [3:0]           sample_cnt_q, sample_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 busy_q;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 deliver_q, deliver_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q, par_bit_d;
   logic                 par_err_q, par_err_d;
`endif

   assign tick_s = BaudClock16 & ~baud_q;

   // Receive state machine; advances only on a baud tick.
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      frame_err_d  = 1'b0;
      deliver_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d    = par_bit_q;
      par_err_d    = 1'b0;
`endif
      if (tick_s) begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d      = START;
                  sample_cnt_d = 4'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            START: begin
               if (sample_cnt_q == 4'd7) begin
                  if (!rx_s_q) begin
                     state_d      = DATA;
                     sample_cnt_d = 4'd0;
                     bit_cnt_d    = 3'd0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + 4'd1;
               end
            end
            DATA: begin
               if (sample_cnt_q == 4'd15) begin
                  shift_d      = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  sample_cnt_d = 4'd0;
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + 4'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sample_cnt_q == 4'd15) begin
                  par_bit_d    = rx_s_q;
                  sample_cnt_d = 4'd0;
                  state_d      = STOP;
               end else begin
                  sample_cnt_d = sample_cnt_q + 4'd1;
               end
            end
`endif
            STOP: begin
               if (sample_cnt_q == 4'd15) begin
                  sample_cnt_d = 4'd0;
                  state_d      = IDLE;
                  frame_err_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                  par_err_d    = (exp_parity(shift_q) != par_bit_q);
                  deliver_d    = rx_s_q & ~par_err_d;
`else
                  deliver_d    = rx_s_q;
`endif
               end else begin
                  sample_cnt_d = sample_cnt_q + 4'd1;
               end
            end
            default: begin
               state_d      = IDLE;
               sample_cnt_d = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Holding register: a delivery into a full, unacked register is an overrun.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (deliver_q) begin
         if (valid_q && !RxAck) begin
            overrun_d = 1'b1;
         end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end
      end else if (RxAck && valid_q) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State, synchroniser and output registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         baud_q       <= 1'b0;
         state_q      <= IDLE;
         sample_cnt_q <= 4'd0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         deliver_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         par_err_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q    <= RxD;
         rx_s_q       <= rx_meta_q;
         baud_q       <= BaudClock16;
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         busy_q       <= (state_d != IDLE);
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         deliver_q    <= deliver_d;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= par_bit_d;
         par_err_q    <= par_err_d;
`endif
      end
   end

   assign RxData     = data_q;
   assign RxValid    = valid_q;
   assign RxBusy     = busy_q;
   assign RxFrameErr = frame_err_q;
   assign RxOverrun  = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign RxParErr   = par_err_q;
`else
   assign RxParErr   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, words checked by a monitor process.
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud = 1'b0;
   logic       rxd = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, busy, fe, pe, ov;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
   int start_cyc = 0, valid_cyc = 0;
   logic [7:0] exp_q[$];
   logic       valid_prev = 1'b0, fe_prev = 1'b0, pe_prev = 1'b0, ov_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;

`ifdef UART_RX_PARITY_EN
   localparam int LAT_MIN = 306 + 32;
   localparam int LAT_MAX = 310 + 32;
`else
   localparam int LAT_MIN = 306;
   localparam int LAT_MAX = 310;
`endif

   uart_rx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
      .Clock(clk), .Reset(rst_n), .BaudClock16(baud), .RxD(rxd), .RxAck(ack),
      .RxData(rx_data), .RxValid(rx_valid), .RxBusy(busy),
      .RxFrameErr(fe), .RxParErr(pe), .RxOverrun(ov)
   );

   always #5 clk = ~clk;
   always @(negedge clk) baud = ~baud;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each new word and polices pulse widths.
   always @(negedge clk) begin
      if (rx_valid && !valid_prev) begin
         valid_cyc = cyc;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %h expected none", rx_data);
         end else begin
            check("word", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
         end
      end
      if (rx_valid && valid_prev)
         check("data_stable", {24'd0, rx_data}, {24'd0, data_prev});
      if (fe) begin
         fe_cnt++;
         check("frame_err_width", {31'd0, fe_prev}, 32'd0);
      end
      if (pe) begin
         pe_cnt++;
         check("par_err_width", {31'd0, pe_prev}, 32'd0);
      end
      if (ov) begin
         ov_cnt++;
         check("overrun_width", {31'd0, ov_prev}, 32'd0);
      end
      valid_prev = rx_valid;
      data_prev  = rx_data;
      fe_prev    = fe;
      pe_prev    = pe;
      ov_prev    = ov;
   end

   task automatic drive_bit(input logic b);
      @(negedge clk) rxd = b;
      repeat (31) @(negedge clk);
   endtask

   task automatic idle(input int bits);
      for (int i = 0; i < bits; i++) drive_bit(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit);
      @(negedge clk) rxd = 1'b0;
      start_cyc = cyc;
      repeat (31) @(negedge clk);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (!rx_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid_timeout"}, {31'd0, rx_valid}, 32'd1);
   endtask

   task automatic do_ack(input string name);
      @(negedge clk) ack = 1'b1;
      @(negedge clk) ack = 1'b0;
      check({name, "_ack_clears"}, {31'd0, rx_valid}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0, pe0, ov0;
      repeat (3) @(negedge clk);
      check("reset_state", {18'd0, rx_data, rx_valid, busy, fe, pe, ov, 1'b0}, 32'd0);
      rst_n = 1'b1;
      idle(2);
      check("idle_after_reset", {30'd0, rx_valid, busy}, 32'd0);

      // 1: 0xA5, latency and ack
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, ^8'hA5, 1'b1);
         begin
            repeat (100) @(negedge clk);
            check("busy_mid_frame", {31'd0, busy}, 32'd1);
         end
      join
      wait_valid("t1", 64);
      check("t1_latency_in_window",
            {31'd0, ((valid_cyc - start_cyc) >= LAT_MIN) && ((valid_cyc - start_cyc) <= LAT_MAX)}, 32'd1);
      check("t1_data", {24'd0, rx_data}, 32'h000000A5);
      do_ack("t1");
      idle(1);

      // 2: start glitch
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      @(negedge clk) rxd = 1'b0;
      repeat (8) @(negedge clk);
      check("t2_busy_on_glitch", {31'd0, busy}, 32'd1);
      rxd = 1'b1;
      repeat (48) @(negedge clk);
      check("t2_busy_back_to_idle", {31'd0, busy}, 32'd0);
      check("t2_no_valid", {31'd0, rx_valid}, 32'd0);
      check("t2_no_errors", fe_cnt + pe_cnt + ov_cnt, fe0 + pe0 + ov0);

      // 3: framing error
      fe0 = fe_cnt;
      send_frame(8'h3C, ^8'h3C, 1'b0);
      idle(2);
      check("t3_frame_err_pulses", fe_cnt, fe0 + 1);
      check("t3_no_valid", {31'd0, rx_valid}, 32'd0);
      check("t3_busy_idle", {31'd0, busy}, 32'd0);

      // 4: overrun
      ov0 = ov_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, ^8'h11, 1'b1);
      send_frame(8'h22, ^8'h22, 1'b1);
      idle(1);
      check("t4_overrun_pulses", ov_cnt, ov0 + 1);
      check("t4_data_kept", {24'd0, rx_data}, 32'h00000011);
      check("t4_valid_held", {31'd0, rx_valid}, 32'd1);
      do_ack("t4");

      // 5: reset mid-frame
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      check("t5_busy_before_reset", {31'd0, busy}, 32'd1);
      @(negedge clk) begin rst_n = 1'b0; rxd = 1'b1; end
      @(negedge clk);
      check("t5_reset_state", {18'd0, rx_data, rx_valid, busy, fe, pe, ov, 1'b0}, 32'd0);
      rst_n = 1'b1;
      idle(10);
      check("t5_no_valid_after_abort", {31'd0, rx_valid}, 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, ^8'h5A, 1'b1);
      wait_valid("t5", 64);
      check("t5_data", {24'd0, rx_data}, 32'h0000005A);
      check("t5_no_errors", fe_cnt + pe_cnt + ov_cnt, fe0 + pe0 + ov0);
      do_ack("t5");
      idle(1);

`ifdef UART_RX_PARITY_EN
      // 6: parity (even): 0x07 needs parity bit 1
      pe0 = pe_cnt;
      send_frame(8'h07, 1'b0, 1'b1);
      idle(1);
      check("t6_par_err_pulses", pe_cnt, pe0 + 1);
      check("t6_no_valid", {31'd0, rx_valid}, 32'd0);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      wait_valid("t6", 64);
      check("t6_data", {24'd0, rx_data}, 32'h00000007);
      check("t6_no_new_par_err", pe_cnt, pe0 + 1);
      do_ack("t6");
`else
      check("par_err_never", pe_cnt, 32'd0);
`endif

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
